// File: rtl/pulse_gen.sv
// Multi-channel programmable pulse-train generator: each channel independently emits
// R pulses of W high cycles, each preceded by D low cycles and followed by one low tail cycle.
module pulse_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH*CNT_W-1:0] delay,
    input  logic [NUM_CH*CNT_W-1:0] width,
    input  logic [NUM_CH*REP_W-1:0] reps,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        TAIL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t           state_r, state_s;
        logic [CNT_W-1:0] d_lat_r, d_lat_s;
        logic [CNT_W-1:0] w_lat_r, w_lat_s;
        logic [CNT_W-1:0] cnt_r, cnt_s;
        logic [REP_W-1:0] rem_r, rem_s;
        logic [CNT_W-1:0] d_in_s, w_in_s;
        logic [REP_W-1:0] r_in_s;

        // Input slice for this channel; zero width/reps are promoted to one.
        always_comb begin
            d_in_s = delay[ch*CNT_W +: CNT_W];
            w_in_s = (width[ch*CNT_W +: CNT_W] == CNT_ZERO) ? CNT_ONE : width[ch*CNT_W +: CNT_W];
            r_in_s = (reps[ch*REP_W +: REP_W] == REP_ZERO) ? REP_ONE : reps[ch*REP_W +: REP_W];
        end

        // Next-state logic; cnt holds remaining cycles of the current phase minus one.
        always_comb begin
            state_s = state_r;
            d_lat_s = d_lat_r;
            w_lat_s = w_lat_r;
            cnt_s   = cnt_r;
            rem_s   = rem_r;
            case (state_r)
                IDLE: begin
                    if (start[ch] && !abort[ch]) begin
                        d_lat_s = d_in_s;
                        w_lat_s = w_in_s;
                        rem_s   = r_in_s - REP_ONE;
                        if (d_in_s != CNT_ZERO) begin
                            state_s = DELAY;
                            cnt_s   = d_in_s - CNT_ONE;
                        end else begin
                            state_s = HIGH;
                            cnt_s   = w_in_s - CNT_ONE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                DELAY: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_s = HIGH;
                        cnt_s   = w_lat_r - CNT_ONE;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                HIGH: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_s = TAIL;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                TAIL: begin
                    if (rem_r == REP_ZERO) begin
                        state_s = IDLE;
                    end else if (d_lat_r != CNT_ZERO) begin
                        rem_s   = rem_r - REP_ONE;
                        state_s = DELAY;
                        cnt_s   = d_lat_r - CNT_ONE;
                    end else begin
                        rem_s   = rem_r - REP_ONE;
                        state_s = HIGH;
                        cnt_s   = w_lat_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
            if (abort[ch]) begin
                state_s = IDLE;
            end else begin
                state_s = state_s;
            end
        end

        // State, latched parameters and outputs decoded from the next state so they are registered.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_r       <= IDLE;
                d_lat_r       <= CNT_ZERO;
                w_lat_r       <= CNT_ONE;
                cnt_r         <= CNT_ZERO;
                rem_r         <= REP_ZERO;
                pulse_out[ch] <= 1'b0;
                busy[ch]      <= 1'b0;
                done[ch]      <= 1'b0;
            end else begin
                state_r       <= state_s;
                d_lat_r       <= d_lat_s;
                w_lat_r       <= w_lat_s;
                cnt_r         <= cnt_s;
                rem_r         <= rem_s;
                pulse_out[ch] <= (state_s == HIGH);
                busy[ch]      <= (state_s != IDLE);
                done[ch]      <= (state_s == TAIL) && (rem_s == REP_ZERO);
            end
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: per-cycle comparison of {busy, pulse_out, done}
// against a timing model built from the channel's D/W/R values.
module tb_pulse_gen;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 10;
    localparam int REP_W  = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*CNT_W-1:0] delay;
    logic [NUM_CH*CNT_W-1:0] width;
    logic [NUM_CH*REP_W-1:0] reps;
    logic [NUM_CH-1:0]       pulse_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;

    int n_cmp;
    int n_bad;
    int dd [NUM_CH];
    int ww [NUM_CH];
    int rr [NUM_CH];
    logic [NUM_CH-1:0] act;

    pulse_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .delay     (delay),
        .width     (width),
        .reps      (reps),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected {busy, pulse, done} at cycle c of an undisturbed train started at edge 0.
    function automatic logic [2:0] model(input int d, input int w, input int r, input int c);
        int we, re, p, pos;
        we = (w == 0) ? 1 : w;
        re = (r == 0) ? 1 : r;
        p  = d + we + 1;
        if (c < 1 || c > re * p) return 3'b000;
        pos = (c - 1) % p;
        return {1'b1, (pos >= d) && (pos < d + we), c == re * p};
    endfunction

    function automatic logic [2:0] observed(input int ch);
        return {busy[ch], pulse_out[ch], done[ch]};
    endfunction

    task automatic load_inputs();
        for (int i = 0; i < NUM_CH; i++) begin
            delay[i*CNT_W +: CNT_W] = CNT_W'(dd[i]);
            width[i*CNT_W +: CNT_W] = CNT_W'(ww[i]);
            reps[i*REP_W +: REP_W]  = REP_W'(rr[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = '0;
        abort = '0;
        step();
        rst_n = 1'b1;
    endtask

    // Start channels in act at edge 0, scramble inputs and re-pulse start while busy,
    // optionally abort one channel or reset at a given edge; check every cycle 1..ncyc.
    task automatic run(input string name, input int ncyc, input int ab_ch, input int ab_edge, input int rst_edge);
        logic [2:0] exp;
        load_inputs();
        start = act;
        step();
        start = '0;
        delay = '1;
        width = '0;
        reps  = '1;
        for (int c = 1; c <= ncyc; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp = act[i] ? model(dd[i], ww[i], rr[i], c) : 3'b000;
                if (ab_edge >= 0 && i == ab_ch && c > ab_edge) exp = 3'b000;
                if (rst_edge >= 0 && c > rst_edge) exp = 3'b000;
                check($sformatf("%s c%0d ch%0d {busy,pulse,done}", name, c, i), 32'(observed(i)), 32'(exp));
            end
            start = (c == 2) ? act : '0;
            abort = '0;
            if (c == ab_edge) abort[ab_ch] = 1'b1;
            rst_n = (c == rst_edge) ? 1'b0 : 1'b1;
            step();
        end
        start = '0;
        abort = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp37 [1:7];
        n_cmp = 0;
        n_bad = 0;
        start = '0;
        abort = '0;
        delay = '0;
        width = '0;
        reps  = '0;
        rst_n = 1'b0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset pulse", 32'(pulse_out), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Basic trains: D3 W2 R1 and D0 W0 R3
        dd = '{3, 0, 0, 0}; ww = '{2, 0, 0, 0}; rr = '{1, 3, 0, 0}; act = 4'b0011;
        run("basic", 9, -1, -1, -1);

        // Abort ch2 at edge 5 while ch3 runs on
        do_reset();
        dd = '{0, 0, 2, 1}; ww = '{0, 0, 4, 3}; rr = '{0, 0, 2, 2}; act = 4'b1100;
        run("abort", 14, 2, 5, -1);

        // Abort together with start in IDLE: start discarded
        do_reset();
        dd = '{0, 0, 0, 0}; ww = '{1, 1, 1, 1}; rr = '{1, 1, 1, 1}; act = 4'b0000;
        load_inputs();
        start = 4'b0001;
        abort = 4'b0001;
        step();
        start = '0;
        abort = '0;
        check("abort+start busy", 32'(busy), 32'd0);
        check("abort+start pulse", 32'(pulse_out), 32'd0);

        // All channels then reset at edge 4, followed by a fresh train
        do_reset();
        dd = '{1, 0, 2, 3}; ww = '{2, 3, 0, 1}; rr = '{2, 3, 1, 4}; act = 4'b1111;
        run("rst_mid", 8, -1, -1, 4);
        dd = '{3, 0, 0, 0}; ww = '{2, 0, 0, 0}; rr = '{1, 0, 0, 0}; act = 4'b0001;
        run("after_rst", 8, -1, -1, -1);

        // Start sampled together with reset is ignored
        dd = '{0, 0, 0, 0}; ww = '{1, 1, 1, 1}; rr = '{1, 1, 1, 1};
        load_inputs();
        rst_n = 1'b0;
        start = 4'b1111;
        step();
        rst_n = 1'b1;
        start = '0;
        check("start@rst busy", 32'(busy), 32'd0);
        step();
        check("start@rst busy later", 32'(busy), 32'd0);
        check("start@rst pulse later", 32'(pulse_out), 32'd0);

        // Ignored start while busy, input change mid-train, restart after done
        do_reset();
        exp37 = '{3'b100, 3'b110, 3'b101, 3'b000, 3'b100, 3'b110, 3'b101};
        dd = '{1, 0, 0, 0}; ww = '{1, 0, 0, 0}; rr = '{1, 0, 0, 0};
        load_inputs();
        start = 4'b0001;
        step();
        start = '0;
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("restart c%0d ch0", c), 32'(observed(0)), 32'(exp37[c]));
            delay[0 +: CNT_W] = (c == 1) ? CNT_W'(5) : CNT_W'(1);
            start = (c == 2 || c == 4) ? 4'b0001 : 4'b0000;
            step();
        end
        start = '0;

        // Counter extremes: max delay, max width, max reps
        do_reset();
        dd = '{1023, 0, 0, 0}; ww = '{1, 0, 1023, 0}; rr = '{1, 15, 1, 0}; act = 4'b0111;
        run("max", 1027, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
